// File: rtl/sipo_frame_ctrl.sv
// Framed serial receiver: start bit, WIDTH data bits MSB first, optional even parity, stop bit.
// The received word is held in po and offered to the consumer on a valid/ready handshake.
module sipo_frame_ctrl #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  input  logic             bit_en,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             busy,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_r;
  state_t           next_s;
  logic [WIDTH-1:0] shift_r;
  logic [CW-1:0]    cnt_r;
  logic             perr_r;
  logic             load_s;
  logic             perr_pulse_s;
  logic             ferr_pulse_s;
  logic             ovr_pulse_s;

  function automatic logic odd_ones(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= next_s;
  end

  // Next-state logic; the FSM only advances on bit strobes
  always_comb begin
    next_s = state_r;
    if (bit_en) begin
      case (state_r)
        IDLE:    next_s = si ? IDLE : DATA;
        DATA:    begin
          if (cnt_r == LAST) next_s = PARITY_EN ? PARITY : STOP;
          else               next_s = DATA;
        end
        PARITY:  next_s = STOP;
        STOP:    next_s = IDLE;
        default: next_s = IDLE;
      endcase
    end else begin
      next_s = state_r;
    end
  end

  // Stop-bit outcome decode; frame error outranks parity error, which outranks overrun
  always_comb begin
    load_s       = 1'b0;
    perr_pulse_s = 1'b0;
    ferr_pulse_s = 1'b0;
    ovr_pulse_s  = 1'b0;
    if (bit_en && (state_r == STOP)) begin
      if (!si)                         ferr_pulse_s = 1'b1;
      else if (perr_r)                 perr_pulse_s = 1'b1;
      else if (po_valid && !po_ready)  ovr_pulse_s  = 1'b1;
      else                             load_s       = 1'b1;
    end else begin
      load_s = 1'b0;
    end
  end

  // Shift register, bit counter and parity accumulator
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r <= '0;
      cnt_r   <= '0;
      perr_r  <= 1'b0;
    end else if (bit_en) begin
      case (state_r)
        IDLE: begin
          if (!si) begin
            cnt_r  <= '0;
            perr_r <= 1'b0;
          end
        end
        DATA: begin
          shift_r <= {shift_r[WIDTH-2:0], si};
          cnt_r   <= cnt_r + CW'(1);
        end
        PARITY: begin
          if (PARITY_EN) perr_r <= odd_ones(shift_r) ^ si;
          else           perr_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Holding register, handshake and one-cycle status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      po         <= '0;
      po_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load_s) begin
        po       <= shift_r;
        po_valid <= 1'b1;
      end else if (po_valid && po_ready) begin
        po_valid <= 1'b0;
      end
      parity_err <= perr_pulse_s;
      frame_err  <= ferr_pulse_s;
      overrun    <= ovr_pulse_s;
    end
  end

  assign busy = (state_r != IDLE);

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench: parity-enabled receiver with a continuous strobe, plus a
// parity-less receiver driven by a strobe on every 4th clock.
module tb_sipo_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       si_a, bit_en_a, ready_a;
  logic [7:0] po_a;
  logic       valid_a, busy_a, perr_a, ferr_a, ovr_a;
  logic       si_b, bit_en_b, ready_b;
  logic [7:0] po_b;
  logic       valid_b, busy_b, perr_b, ferr_b, ovr_b;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sipo_frame_ctrl #(.WIDTH(8), .PARITY_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .si(si_a), .bit_en(bit_en_a),
    .po(po_a), .po_valid(valid_a), .po_ready(ready_a), .busy(busy_a),
    .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a)
  );

  sipo_frame_ctrl #(.WIDTH(8), .PARITY_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .si(si_b), .bit_en(bit_en_b),
    .po(po_b), .po_valid(valid_b), .po_ready(ready_b), .busy(busy_b),
    .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start bit, data MSB first, parity bit; the stop bit is sent separately
  task automatic body_a(input logic [7:0] d, input logic par);
    si_a = 1'b0;
    tick();
    for (int i = 7; i >= 0; i--) begin
      si_a = d[i];
      tick();
    end
    si_a = par;
    tick();
  endtask

  task automatic stop_a(input logic s);
    si_a = s;
    tick();
    si_a = 1'b1;
  endtask

  task automatic flags_a(input string tag, input logic pe, input logic fe, input logic ov);
    chk({tag, "_perr"}, {31'd0, perr_a}, {31'd0, pe});
    chk({tag, "_ferr"}, {31'd0, ferr_a}, {31'd0, fe});
    chk({tag, "_ovr"},  {31'd0, ovr_a},  {31'd0, ov});
  endtask

  // one strobed bit followed by three non-strobe clocks with the line inverted
  task automatic strobe_b(input logic b);
    si_b     = b;
    bit_en_b = 1'b1;
    tick();
    bit_en_b = 1'b0;
    si_b     = ~b;
    for (int k = 0; k < 3; k++) tick();
  endtask

  initial begin
    logic [7:0] word_b;
    logic [7:0] exp_shift;
    rst = 1'b0;
    si_a = 1'b1; bit_en_a = 1'b1; ready_a = 1'b1;
    si_b = 1'b1; bit_en_b = 1'b0; ready_b = 1'b0;
    #2;
    chk("rst_po",    {24'd0, po_a},     32'd0);
    chk("rst_valid", {31'd0, valid_a},  32'd0);
    chk("rst_busy",  {31'd0, busy_a},   32'd0);
    flags_a("rst", 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // A5 with wrong parity bit
    body_a(8'hA5, 1'b1);
    chk("perr_busy", {31'd0, busy_a}, 32'd1);
    stop_a(1'b1);
    flags_a("perr", 1'b1, 1'b0, 1'b0);
    chk("perr_valid", {31'd0, valid_a}, 32'd0);
    chk("perr_po",    {24'd0, po_a},    32'd0);
    tick();
    chk("perr_pulse_end", {31'd0, perr_a}, 32'd0);

    // A5 good frame
    body_a(8'hA5, 1'b0);
    stop_a(1'b1);
    chk("a5_po",    {24'd0, po_a},    32'h0000_00A5);
    chk("a5_valid", {31'd0, valid_a}, 32'd1);
    chk("a5_busy",  {31'd0, busy_a},  32'd0);
    flags_a("a5", 1'b0, 1'b0, 1'b0);
    tick();
    chk("a5_valid_drop", {31'd0, valid_a}, 32'd0);
    chk("a5_po_hold",    {24'd0, po_a},    32'h0000_00A5);

    // 3C with stop bit 0, then frame error outranking a parity error
    body_a(8'h3C, 1'b0);
    stop_a(1'b0);
    flags_a("fe1", 1'b0, 1'b1, 1'b0);
    chk("fe1_valid", {31'd0, valid_a}, 32'd0);
    tick();
    chk("fe1_pulse_end", {31'd0, ferr_a}, 32'd0);
    body_a(8'h3C, 1'b1);
    stop_a(1'b0);
    flags_a("fe2", 1'b0, 1'b1, 1'b0);
    body_a(8'h81, 1'b0);
    stop_a(1'b1);
    chk("x81_po",    {24'd0, po_a},    32'h0000_0081);
    chk("x81_valid", {31'd0, valid_a}, 32'd1);
    tick();

    // overrun, then load coinciding with a handshake
    ready_a = 1'b0;
    body_a(8'h11, 1'b0);
    stop_a(1'b1);
    chk("x11_po",    {24'd0, po_a},    32'h0000_0011);
    chk("x11_valid", {31'd0, valid_a}, 32'd1);
    body_a(8'h22, 1'b0);
    stop_a(1'b1);
    flags_a("ovr", 1'b0, 1'b0, 1'b1);
    chk("ovr_po",    {24'd0, po_a},    32'h0000_0011);
    chk("ovr_valid", {31'd0, valid_a}, 32'd1);
    tick();
    chk("ovr_pulse_end", {31'd0, ovr_a}, 32'd0);
    body_a(8'h22, 1'b0);
    ready_a = 1'b1;
    stop_a(1'b1);
    ready_a = 1'b0;
    chk("x22_po",    {24'd0, po_a},    32'h0000_0022);
    chk("x22_valid", {31'd0, valid_a}, 32'd1);
    flags_a("x22", 1'b0, 1'b0, 1'b0);
    tick();
    chk("x22_valid_held", {31'd0, valid_a}, 32'd1);

    // reset in the middle of a frame
    si_a = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      si_a = 1'b1;
      tick();
    end
    chk("mid_busy", {31'd0, busy_a}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy",  {31'd0, busy_a},  32'd0);
    chk("mid_rst_po",    {24'd0, po_a},    32'd0);
    chk("mid_rst_valid", {31'd0, valid_a}, 32'd0);
    flags_a("mid_rst", 1'b0, 1'b0, 1'b0);
    #1;
    rst  = 1'b1;
    si_a = 1'b1;
    ready_a = 1'b1;
    tick();
    body_a(8'h0F, 1'b0);
    stop_a(1'b1);
    chk("x0f_po",    {24'd0, po_a},    32'h0000_000F);
    chk("x0f_valid", {31'd0, valid_a}, 32'd1);
    flags_a("x0f", 1'b0, 1'b0, 1'b0);

    // parity-less receiver with a sparse strobe
    word_b    = 8'hC3;
    exp_shift = 8'h00;
    strobe_b(1'b0);
    chk("b_start_busy",  {31'd0, busy_b}, 32'd1);
    chk("b_start_shift", {24'd0, dut_b.shift_r}, 32'd0);
    for (int i = 7; i >= 0; i--) begin
      strobe_b(word_b[i]);
      exp_shift = {exp_shift[6:0], word_b[i]};
      chk("b_shift", {24'd0, dut_b.shift_r}, {24'd0, exp_shift});
      chk("b_busy",  {31'd0, busy_b},        32'd1);
    end
    chk("b_valid_pre", {31'd0, valid_b}, 32'd0);
    strobe_b(1'b1);
    chk("b_po",    {24'd0, po_b},    32'h0000_00C3);
    chk("b_valid", {31'd0, valid_b}, 32'd1);
    chk("b_busy_end", {31'd0, busy_b}, 32'd0);
    chk("b_errs", {29'd0, perr_b, ferr_b, ovr_b}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
- Controller that sequences a serial-in/parallel-out shift register to receive framed serial words.
- Each frame is: start bit, WIDTH data bits (MSB first, left shift), optional even-parity bit, stop bit.
- A received word is moved into an output holding register and presented on a valid/ready handshake.
- The block sits between a bit-rate strobe generator and a parallel consumer.

Parameters:
- WIDTH, 8, number of data bits per frame (range 2..32).
- PARITY_EN, 1, 1 = an even-parity bit follows the data bits; 0 = no parity bit.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- si  input  1  serial data line; idle level 1.
- bit_en  input  1  bit strobe; si is sampled only on clk edges where bit_en=1.
- po  output  WIDTH  received word (holding register).
- po_valid  output  1  po holds an unconsumed word.
- po_ready  input  1  consumer accepts po when po_valid=1 and po_ready=1.
- busy  output  1  1 in any state other than IDLE.
- parity_err  output  1  one-cycle pulse: parity mismatch; frame discarded.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0; frame discarded.
- overrun  output  1  one-cycle pulse: good frame dropped because the holding register was still full.

Behaviour:
- Reset (rst=0, async): state=IDLE, shift reg=0, bit counter=0, po=0, po_valid=0, busy=0, all pulses 0. A reset mid-frame abandons the frame; no error pulse is generated.
- All state changes except the po_ready handshake occur only on edges with bit_en=1. With bit_en=0 the FSM and shift register hold.
- FSM transitions:
  - IDLE: si=0 -> DATA, counter=0. si=1 -> stay.
  - DATA: shift_reg <= {shift_reg[WIDTH-2:0], si}; counter++. On the WIDTH-th bit (counter==WIDTH-1): -> PARITY if PARITY_EN=1, else -> STOP.
  - PARITY: perr <= (^shift_reg) ^ si. Even parity: the total count of 1s over data plus parity bit must be even. -> STOP.
  - STOP, si=1, perr=1: parity_err pulse; drop the frame.
  - STOP, si=1, perr=0, po_valid=1 and po_ready=0: overrun pulse; drop the frame; po is unchanged.
  - STOP, si=1, otherwise: po <= shift_reg; po_valid <= 1.
  - STOP, si=0: frame_err pulse; drop the frame. frame_err takes precedence over parity_err.
  - All STOP outcomes -> IDLE.
- perr is cleared on entry to DATA and is always 0 when PARITY_EN=0.
- Timing: all outputs are registered. po, po_valid and the error pulses change in the cycle after the clk edge that sampled the stop bit. Each pulse lasts exactly one clk cycle.
- Handshake:
  - po_valid=1 and po_ready=1 with no load on that edge: po_valid <= 0; po is held.
  - A load and a handshake on the same edge: the load wins. po takes the new word and po_valid stays 1; there is no overrun.
  - po is stable while po_valid=1.
- busy is combinational from state (state != IDLE).
- Back-to-back frames: a start bit may be sampled on the first bit_en after STOP. No idle gap is required.
- bit_en held at 1 every cycle is legal; one bit is taken per clk.

Test Plan:
- WIDTH=8, PARITY_EN=1; send 0,1,0,1,0,0,1,0,1 then parity 0, stop 1 with po_ready=1 -> po=8'hA5, po_valid high for 1 cycle, no error pulses.
- Same frame with parity bit 1 -> parity_err single pulse, po_valid stays 0, po remains 0.
- Frame 8'h3C (parity 0) with stop bit 0 -> frame_err pulse, no parity_err, po_valid=0; the next good frame 8'h81 (parity 0) loads po=8'h81.
- po_ready=0; send 8'h11 then 8'h22 -> po=8'h11, po_valid=1, overrun pulse on the second stop. Then raise po_ready and send 8'h22 while asserting po_ready on the load edge -> po=8'h22, po_valid remains 1.
- Assert rst=0 mid-DATA after 4 bits of 8'hF0 -> busy=0 and po/po_valid=0 immediately; after release, 8'h0F is received correctly.
- PARITY_EN=0, bit_en high only every 4th cycle; send 8'hC3 -> po=8'hC3; shift register and state are unchanged on non-strobe cycles.
